// File: rtl/writeback_unit.sv
// writeback_unit: merges ALU results and buffered, formatted loads onto the register-file write port.
// Optional WB_BYPASS_EN adds combinational forwarding outputs of the result selected this cycle.
module writeback_unit #(
   parameter int XLEN            = 32,
   parameter int LOAD_FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            aluValid,
   output logic            aluReady,
   input  logic [4:0]      aluRd,
   input  logic [XLEN-1:0] aluResult,
   input  logic            memRespValid,
   output logic            memRespReady,
   input  logic [4:0]      memRd,
   input  logic [2:0]      memFunct3,
   input  logic [1:0]      memByteOffset,
   input  logic [XLEN-1:0] memRdata,
   output logic [4:0]      writeAddr,
   output logic [XLEN-1:0] writeData,
   output logic            writeEnable,
   output logic            loadErr
`ifdef WB_BYPASS_EN
   ,
   output logic            bypassValid,
   output logic [4:0]      bypassRd,
   output logic [XLEN-1:0] bypassData
`endif
);
   localparam int AW = $clog2(LOAD_FIFO_DEPTH);
   localparam logic [AW:0] FULL = LOAD_FIFO_DEPTH[AW:0];
   logic [XLEN-1:0] r_data [LOAD_FIFO_DEPTH];
   logic [4:0]      r_rd   [LOAD_FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
   logic [AW:0]     r_count;
   logic [4:0]      r_waddr;
   logic [XLEN-1:0] r_wdata;
   logic            r_we, r_err;
   logic [XLEN-1:0] w_shift, w_ld_data, w_sel_data;
   logic [4:0]      w_sel_rd;
   logic            w_ld_err, w_full, w_push, w_pop, w_alu_acc, w_sel_valid;
   assign w_full       = r_count == FULL;
   assign memRespReady = !w_full;
   assign w_push       = memRespValid & memRespReady;
   assign w_alu_acc    = aluValid & !w_full;
   assign aluReady     = w_alu_acc;
   // A full FIFO takes the port so the ALU can never starve load responses.
   assign w_pop        = w_full | (!aluValid & (r_count != '0));
   assign w_sel_valid  = w_alu_acc | w_pop;
   assign w_sel_rd     = w_alu_acc ? aluRd : r_rd[r_rd_ptr];
   assign w_sel_data   = w_alu_acc ? aluResult : r_data[r_rd_ptr];
   assign w_shift      = memRdata >> {memByteOffset, 3'b000};
   always_comb begin
      w_ld_err  = 1'b0;
      w_ld_data = '0;
      case (memFunct3)
         3'b000:  w_ld_data = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
         3'b100:  w_ld_data = {{(XLEN-8){1'b0}}, w_shift[7:0]};
         3'b001:  begin
            w_ld_err  = memByteOffset[0];
            w_ld_data = memByteOffset[0] ? '0 : {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
         end
         3'b101:  begin
            w_ld_err  = memByteOffset[0];
            w_ld_data = memByteOffset[0] ? '0 : {{(XLEN-16){1'b0}}, w_shift[15:0]};
         end
         3'b010:  begin
            w_ld_err  = memByteOffset != 2'b00;
            w_ld_data = w_ld_err ? '0 : memRdata;
         end
         default: w_ld_err = 1'b1;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
         r_wdata  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) begin
            r_data[r_wr_ptr] <= w_ld_data;
            r_rd[r_wr_ptr]   <= memRd;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
         r_we    <= w_sel_valid & (w_sel_rd != 5'd0);
         if (w_sel_valid && w_sel_rd != 5'd0) begin
            r_waddr <= w_sel_rd;
            r_wdata <= w_sel_data;
         end
         r_err <= w_push & w_ld_err;
      end
   end
   assign writeAddr   = r_waddr;
   assign writeData   = r_wdata;
   assign writeEnable = r_we;
   assign loadErr     = r_err;
`ifdef WB_BYPASS_EN
   assign bypassValid = !rst & w_sel_valid & (w_sel_rd != 5'd0);
   assign bypassRd    = w_sel_rd;
   assign bypassData  = w_sel_data;
`endif
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of ALU/load merging, load formatting, arbitration and reset.
module tb_writeback_unit;
   logic        clk = 1'b0;
   logic        rst, aluValid, aluReady, memRespValid, memRespReady;
   logic [4:0]  aluRd, memRd, writeAddr;
   logic [31:0] aluResult, memRdata, writeData;
   logic [2:0]  memFunct3;
   logic [1:0]  memByteOffset;
   logic        writeEnable, loadErr;
   int          n_tests = 0, n_fail = 0;
`ifdef WB_BYPASS_EN
   logic        bypassValid;
   logic [4:0]  bypassRd;
   logic [31:0] bypassData;
`endif
   writeback_unit dut (
      .clk(clk), .rst(rst), .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd),
      .aluResult(aluResult), .memRespValid(memRespValid), .memRespReady(memRespReady),
      .memRd(memRd), .memFunct3(memFunct3), .memByteOffset(memByteOffset), .memRdata(memRdata),
      .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable), .loadErr(loadErr)
`ifdef WB_BYPASS_EN
      , .bypassValid(bypassValid), .bypassRd(bypassRd), .bypassData(bypassData)
`endif
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
      memRespValid = 1'b1; memRd = rd; memFunct3 = f3; memByteOffset = off; memRdata = d;
   endtask
   initial begin
      rst = 1'b1; aluValid = 1'b0; aluRd = '0; aluResult = '0;
      memRespValid = 1'b0; memRd = '0; memFunct3 = '0; memByteOffset = '0; memRdata = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_we", writeEnable, 0);
      chk("rst_addr", writeAddr, 0);
      chk("rst_data", writeData, 0);
      chk("rst_err", loadErr, 0);
      chk("rst_ready", memRespReady, 1);
      aluValid = 1'b1; aluRd = 5'd5; aluResult = 32'h02312313;
      #1 chk("alu_ready", aluReady, 1);
`ifdef WB_BYPASS_EN
      chk("byp_valid", bypassValid, 1);
      chk("byp_data", bypassData, 32'h02312313);
`endif
      tick();
      aluValid = 1'b0;
      chk("alu_we", writeEnable, 1);
      chk("alu_addr", writeAddr, 5);
      chk("alu_data", writeData, 32'h02312313);
      tick();
      chk("idle_we", writeEnable, 0);
      chk("idle_addr_hold", writeAddr, 5);
      load(5'd7, 3'b000, 2'd2, 32'h00F00000);
      tick();
      memRespValid = 1'b0;
      chk("lb_err", loadErr, 0);
      tick();
      chk("lb_we", writeEnable, 1);
      chk("lb_addr", writeAddr, 7);
      chk("lb_data", writeData, 32'hFFFFFFF0);
      load(5'd8, 3'b100, 2'd2, 32'h00F00000);
      tick();
      memRespValid = 1'b0;
      tick();
      chk("lbu_addr", writeAddr, 8);
      chk("lbu_data", writeData, 32'h000000F0);
      load(5'd9, 3'b001, 2'd1, 32'h12345678);
      tick();
      memRespValid = 1'b0;
      chk("lh_mis_err", loadErr, 1);
      tick();
      chk("lh_mis_err_pulse", loadErr, 0);
      chk("lh_mis_we", writeEnable, 1);
      chk("lh_mis_addr", writeAddr, 9);
      chk("lh_mis_data", writeData, 0);
      aluValid = 1'b1; aluRd = 5'd3; aluResult = 32'h0000A000;
      load(5'd10, 3'b010, 2'd0, 32'h11111111);
      #1 chk("cont_alu_ready0", aluReady, 1);
      tick();
      chk("cont_a0", writeData, 32'h0000A000);
      aluResult = 32'h0000A001;
      load(5'd11, 3'b010, 2'd0, 32'h22222222);
      tick();
      chk("cont_a1", writeData, 32'h0000A001);
      memRespValid = 1'b0; aluResult = 32'h0000A002;
      #1 chk("cont_full_alu_stall", aluReady, 0);
      chk("cont_full_mem_ready", memRespReady, 0);
      tick();
      chk("cont_ld0_addr", writeAddr, 10);
      chk("cont_ld0_data", writeData, 32'h11111111);
      chk("cont_alu_resume", aluReady, 1);
      tick();
      aluValid = 1'b0;
      chk("cont_a2_addr", writeAddr, 3);
      chk("cont_a2_data", writeData, 32'h0000A002);
      tick();
      chk("cont_ld1_we", writeEnable, 1);
      chk("cont_ld1_addr", writeAddr, 11);
      chk("cont_ld1_data", writeData, 32'h22222222);
      aluValid = 1'b1; aluRd = 5'd0; aluResult = 32'hDEADBEEF;
      #1 chk("x0_ready", aluReady, 1);
      tick();
      chk("x0_we", writeEnable, 0);
      load(5'd12, 3'b010, 2'd0, 32'h12121212);
      tick();
      memRd = 5'd13;
      tick();
      chk("pre_rst_full", memRespReady, 0);
      rst = 1'b1; aluValid = 1'b0; memRespValid = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid_rst_we", writeEnable, 0);
      chk("mid_rst_ready", memRespReady, 1);
      tick();
      chk("mid_rst_no_stale1", writeEnable, 0);
      tick();
      chk("mid_rst_no_stale2", writeEnable, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
